// File: rtl/mem_map_pkg.sv
// Shared types and default address map for the CPU load/store bus controller.
package mem_map_pkg;

  typedef enum logic [1:0] {REG_NONE, REG_ROM, REG_RAM, REG_IO} region_e;
  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_IO, ST_RESP} state_e;

  localparam logic [31:0] DEF_ROM_BASE  = 32'h0001_0000;
  localparam logic [31:0] DEF_ROM_LIMIT = 32'h000F_FFFF;
  localparam logic [31:0] DEF_RAM_BASE  = 32'h0010_0000;
  localparam logic [31:0] DEF_RAM_LIMIT = 32'hFF0F_FFFF;
  localparam logic [31:0] DEF_IO_BASE   = 32'hFF10_0000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  // Enabled lanes must stay inside the word once shifted up to the address offset.
  function automatic logic be_fits(input logic [3:0] be, input logic [1:0] ofs);
    logic [7:0] sh;
    sh = {4'b0, be} << ofs;
    return sh[7:4] == 4'b0;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// CPU-side request/response bus of the memory controller.
interface mem_bus_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_addr_decode.sv
// Combinational region decode plus access-fault check for one request.
module mem_addr_decode
  import mem_map_pkg::*;
#(
  parameter logic [31:0] ROM_BASE  = DEF_ROM_BASE,
  parameter logic [31:0] ROM_LIMIT = DEF_ROM_LIMIT,
  parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
  parameter logic [31:0] RAM_LIMIT = DEF_RAM_LIMIT,
  parameter logic [31:0] IO_BASE   = DEF_IO_BASE
) (
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  be,
  output region_e     region,
  output logic        fault
);

  always_comb begin
    region = REG_NONE;
    if (addr >= IO_BASE)                           region = REG_IO;
    else if (addr >= RAM_BASE && addr <= RAM_LIMIT) region = REG_RAM;
    else if (addr >= ROM_BASE && addr <= ROM_LIMIT) region = REG_ROM;
  end

  assign fault = (region == REG_NONE)
               | (we && region == REG_ROM)
               | (be == 4'b0)
               | !be_fits(be, addr[1:0]);

endmodule

// File: rtl/mem_bus_ctrl.sv
// One-outstanding-request bus controller routing CPU loads/stores to ROM, RAM or MMIO.
module mem_bus_ctrl
  import mem_map_pkg::*;
#(
  parameter logic [31:0] ROM_BASE   = DEF_ROM_BASE,
  parameter logic [31:0] ROM_LIMIT  = DEF_ROM_LIMIT,
  parameter logic [31:0] RAM_BASE   = DEF_RAM_BASE,
  parameter logic [31:0] RAM_LIMIT  = DEF_RAM_LIMIT,
  parameter logic [31:0] IO_BASE    = DEF_IO_BASE,
  parameter int          MEM_LAT    = 1,
  parameter int          IO_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  mem_bus_ctrl_if.slave bus,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        io_valid,
  output logic        io_we,
  output logic [3:0]  io_be,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic        io_ready,
  input  logic [31:0] io_rdata
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int TO_W  = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(IO_TIMEOUT - 1);

  req_t             req;
  rsp_t             rsp_q;
  region_e          dec_region;
  logic             dec_fault;
  state_e           state;
  logic             ready_q;
  logic             rsp_valid_q;
  logic             accept;
  logic             cur_we;
  logic             cur_fault;
  region_e          cur_region;
  logic [LAT_W-1:0] lat_cnt;
  logic [TO_W-1:0]  to_cnt;

  assign req = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata, be: bus.req_be};

  mem_addr_decode #(
    .ROM_BASE (ROM_BASE),
    .ROM_LIMIT(ROM_LIMIT),
    .RAM_BASE (RAM_BASE),
    .RAM_LIMIT(RAM_LIMIT),
    .IO_BASE  (IO_BASE)
  ) u_dec (
    .addr  (req.addr),
    .we    (req.we),
    .be    (req.be),
    .region(dec_region),
    .fault (dec_fault)
  );

  assign accept        = (state == ST_IDLE) && ready_q && bus.req_valid;
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.rsp_err   = rsp_q.err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      cur_we      <= 1'b0;
      cur_fault   <= 1'b0;
      cur_region  <= REG_NONE;
      lat_cnt     <= '0;
      to_cnt      <= '0;
      rom_addr    <= '0;
      ram_we      <= 1'b0;
      ram_be      <= '0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      io_valid    <= 1'b0;
      io_we       <= 1'b0;
      io_be       <= '0;
      io_addr     <= '0;
      io_wdata    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      ram_we      <= 1'b0;
      case (state)
        ST_IDLE: begin
          ready_q <= !accept;
          if (accept) begin
            cur_we     <= req.we;
            cur_region <= dec_region;
            cur_fault  <= dec_fault;
            to_cnt     <= '0;
            // Faults take one silent MEM cycle, so their response lands
            // with the same accept-to-response spacing as a single-cycle memory access.
            lat_cnt    <= dec_fault ? '0 : LAT_LAST;
            state      <= ST_MEM;
            if (!dec_fault) begin
              case (dec_region)
                REG_ROM: rom_addr <= req.addr - ROM_BASE;
                REG_RAM: begin
                  ram_addr  <= req.addr - RAM_BASE;
                  ram_be    <= req.be;
                  ram_wdata <= req.wdata;
                  ram_we    <= req.we;
                end
                REG_IO: begin
                  io_valid <= 1'b1;
                  io_we    <= req.we;
                  io_be    <= req.be;
                  io_addr  <= req.addr;
                  io_wdata <= req.wdata;
                  state    <= ST_IO;
                end
                default: ;
              endcase
            end
          end
        end
        ST_MEM: begin
          if (lat_cnt == '0) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_q.err   <= cur_fault;
            if (cur_fault || cur_we)         rsp_q.rdata <= '0;
            else if (cur_region == REG_ROM)  rsp_q.rdata <= rom_rdata;
            else                             rsp_q.rdata <= ram_rdata;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        ST_IO: begin
          // A completion on the expiring cycle still wins over the timeout.
          if (io_ready) begin
            io_valid    <= 1'b0;
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_q.err   <= 1'b0;
            rsp_q.rdata <= cur_we ? '0 : io_rdata;
          end else if (to_cnt == TO_LAST) begin
            io_valid    <= 1'b0;
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_q.err   <= 1'b1;
            rsp_q.rdata <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_RESP: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
